// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and default parameters for the pipeline hazard/sequencing controller.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W_DEF      = 4;
  localparam int WAIT_LIMIT_DEF = 63;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Stage-side signal bundle of the hazard controller: pipeline observations in, freeze/flush out.
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic [REG_W-1:0] id_src1;
  logic             id_src1_vld;
  logic [REG_W-1:0] id_src2;
  logic             id_src2_vld;
  logic [REG_W-1:0] exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_read;
  logic [REG_W-1:0] mem_dest;
  logic             mem_wb_en;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             if_freeze;
  logic             if_flush;
  logic             id_flush;
  logic             pipe_freeze;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_src1, id_src1_vld, id_src2, id_src2_vld,
    output exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
    output branch_taken, mem_req, mem_ready,
    input  if_freeze, if_flush, id_flush, pipe_freeze, mem_timeout, stall_cycles
  );

  modport slave (
    input  id_src1, id_src1_vld, id_src2, id_src2_vld,
    input  exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
    input  branch_taken, mem_req, mem_ready,
    output if_freeze, if_flush, id_flush, pipe_freeze, mem_timeout, stall_cycles
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// RAW comparators between ID sources and in-flight destinations.
// HAZ_FORWARDING_EN: stall only on load-use against EXE; otherwise any EXE/MEM match stalls.
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] src1,
  input  logic             src1_vld,
  input  logic [REG_W-1:0] src2,
  input  logic             src2_vld,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  output logic             stall_req
);

  logic [1:0][REG_W-1:0] src;
  logic [1:0]            vld;
  logic [1:0]            hit_exe;
  logic [1:0]            hit_mem;

  assign src = {src2, src1};
  assign vld = {src2_vld, src1_vld};

  // Register 0 is an ordinary register, so no index is excluded from matching.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign hit_exe[gi] = vld[gi] && (src[gi] == exe_dest);
    assign hit_mem[gi] = vld[gi] && (src[gi] == mem_dest);
  end

`ifdef HAZ_FORWARDING_EN
  logic unused_mem;
  assign unused_mem = ^{hit_mem, mem_wb_en};
  assign stall_req  = exe_wb_en && exe_mem_read && (|hit_exe);
`else
  logic unused_load;
  assign unused_load = exe_mem_read;
  assign stall_req   = (exe_wb_en && (|hit_exe)) || (mem_wb_en && (|hit_mem));
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: memory-wait FSM, branch/hazard priority, timeout and stall counter.
// Optional macro HAZ_FORWARDING_EN selects load-use-only stalling in the hazard detector.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W      = REG_W_DEF,
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int WC_W = $clog2(WAIT_LIMIT + 1);

  state_e            state_reg;
  logic [WC_W-1:0]   wait_cnt_reg;
  logic              mem_timeout_reg;
  logic [CNT_W-1:0]  stall_cycles_reg;

  logic stall_req;
  logic frozen;
  logic if_freeze_next;
  logic if_flush_next;
  logic id_flush_next;

  pipe_hazard_ctrl_hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .src1         (bus.id_src1),
    .src1_vld     (bus.id_src1_vld),
    .src2         (bus.id_src2),
    .src2_vld     (bus.id_src2_vld),
    .exe_dest     (bus.exe_dest),
    .exe_wb_en    (bus.exe_wb_en),
    .exe_mem_read (bus.exe_mem_read),
    .mem_dest     (bus.mem_dest),
    .mem_wb_en    (bus.mem_wb_en),
    .stall_req    (stall_req)
  );

  // Gated by rst_n so nothing leaks out while reset is held with a pending access.
  always_comb begin
    frozen         = rst_n && bus.mem_req && !bus.mem_ready;
    if_freeze_next = 1'b0;
    if_flush_next  = 1'b0;
    id_flush_next  = 1'b0;
    if (rst_n && !frozen) begin
      if (bus.branch_taken) begin
        if_flush_next = 1'b1;
        id_flush_next = 1'b1;
      end else if (stall_req) begin
        if_freeze_next = 1'b1;
        id_flush_next  = 1'b1;
      end
    end
  end

  assign bus.pipe_freeze  = frozen;
  assign bus.if_freeze    = if_freeze_next;
  assign bus.if_flush     = if_flush_next;
  assign bus.id_flush     = id_flush_next;
  assign bus.mem_timeout  = mem_timeout_reg;
  assign bus.stall_cycles = stall_cycles_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_RUN;
      wait_cnt_reg     <= '0;
      mem_timeout_reg  <= 1'b0;
      stall_cycles_reg <= '0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (bus.mem_req && !bus.mem_ready) state_reg <= ST_MEM_WAIT;
        end
        ST_MEM_WAIT: begin
          if (bus.mem_ready) begin
            state_reg    <= ST_RUN;
            wait_cnt_reg <= '0;
          end else if (wait_cnt_reg != WC_W'(WAIT_LIMIT)) begin
            wait_cnt_reg <= wait_cnt_reg + WC_W'(1);
          end
        end
        default: state_reg <= ST_RUN;
      endcase

      if (wait_cnt_reg == WC_W'(WAIT_LIMIT)) mem_timeout_reg <= 1'b1;

      if (if_freeze_next && !(&stall_cycles_reg))
        stall_cycles_reg <= stall_cycles_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: vector table, hand corner sequences, randomized run against a rule model.
module tb_pipe_hazard_ctrl;

  localparam int REG_W      = 4;
  localparam int CNT_W      = 4;
  localparam int WAIT_LIMIT = 63;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.REG_W(REG_W), .WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] s1; logic v1; logic [3:0] s2; logic v2;
    logic [3:0] ed; logic ewb; logic erd;
    logic [3:0] md; logic mwb;
    logic br; logic mreq; logic mrdy;
    logic [3:0] exp_nf;  // {if_freeze, if_flush, id_flush, pipe_freeze} without forwarding
    logic [3:0] exp_fw;  // same, forwarding build
  } vec_t;

  int checks = 0;
  int errors = 0;
  int m_stall;
  bit m_timeout;
  int m_streak;  // consecutive frozen cycles ending at the previous cycle

  vec_t vecs[13];
  vec_t lu;
  vec_t v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t x);
    bus.id_src1 = x.s1;  bus.id_src1_vld = x.v1;
    bus.id_src2 = x.s2;  bus.id_src2_vld = x.v2;
    bus.exe_dest = x.ed; bus.exe_wb_en = x.ewb; bus.exe_mem_read = x.erd;
    bus.mem_dest = x.md; bus.mem_wb_en = x.mwb;
    bus.branch_taken = x.br; bus.mem_req = x.mreq; bus.mem_ready = x.mrdy;
  endtask

  task automatic idle();
    vec_t z;
    z = '{4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
    apply(z);
  endtask

  function automatic bit reads(input logic [3:0] r);
    return (bus.id_src1_vld && bus.id_src1 == r) || (bus.id_src2_vld && bus.id_src2 == r);
  endfunction

  function automatic bit model_hazard();
`ifdef HAZ_FORWARDING_EN
    return bus.exe_wb_en && bus.exe_mem_read && reads(bus.exe_dest);
`else
    return (bus.exe_wb_en && reads(bus.exe_dest)) || (bus.mem_wb_en && reads(bus.mem_dest));
`endif
  endfunction

  // Entered at posedge+1 with inputs applied; checks everything, then advances one edge.
  task automatic run_cycle(input string tag);
    bit frz, haz, e_iff, e_ifl, e_idf;
    #2;
    frz   = bus.mem_req && !bus.mem_ready;
    haz   = model_hazard();
    e_iff = !frz && !bus.branch_taken && haz;
    e_ifl = !frz && bus.branch_taken;
    e_idf = !frz && (bus.branch_taken || haz);
    chk({tag, ".pipe_freeze"},  {31'd0, bus.pipe_freeze}, {31'd0, frz});
    chk({tag, ".if_freeze"},    {31'd0, bus.if_freeze},   {31'd0, e_iff});
    chk({tag, ".if_flush"},     {31'd0, bus.if_flush},    {31'd0, e_ifl});
    chk({tag, ".id_flush"},     {31'd0, bus.id_flush},    {31'd0, e_idf});
    chk({tag, ".stall_cycles"}, {28'd0, bus.stall_cycles}, m_stall);
    chk({tag, ".mem_timeout"},  {31'd0, bus.mem_timeout}, {31'd0, m_timeout});
    @(posedge clk);
    if (e_iff && m_stall < CNT_MAX) m_stall++;
    if (m_streak >= WAIT_LIMIT + 1) m_timeout = 1'b1;
    m_streak = frz ? m_streak + 1 : 0;
    #1;
  endtask

  task automatic model_reset();
    m_stall = 0; m_timeout = 1'b0; m_streak = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] e;
    bit prev_frz;

    vecs[0]  = '{4'd1, 1, 4'd2, 1, 4'd3, 1, 0, 4'd4, 1, 0, 0, 1, 4'b0000, 4'b0000};
    vecs[1]  = '{4'd3, 1, 4'd2, 0, 4'd3, 1, 0, 4'd4, 0, 0, 0, 1, 4'b1010, 4'b0000};
    vecs[2]  = '{4'd1, 0, 4'd5, 1, 4'd5, 1, 1, 4'd9, 0, 0, 0, 1, 4'b1010, 4'b1010};
    vecs[3]  = '{4'd7, 1, 4'd0, 0, 4'd2, 1, 0, 4'd7, 1, 0, 0, 1, 4'b1010, 4'b0000};
    vecs[4]  = '{4'd0, 1, 4'd0, 0, 4'd0, 1, 1, 4'd9, 0, 0, 0, 1, 4'b1010, 4'b1010};
    vecs[5]  = '{4'd6, 0, 4'd6, 0, 4'd6, 1, 1, 4'd6, 1, 0, 0, 1, 4'b0000, 4'b0000};
    vecs[6]  = '{4'd6, 1, 4'd8, 1, 4'd6, 0, 1, 4'd8, 0, 0, 0, 1, 4'b0000, 4'b0000};
    vecs[7]  = '{4'd3, 1, 4'd0, 0, 4'd3, 1, 1, 4'd0, 0, 1, 0, 1, 4'b0110, 4'b0110};
    vecs[8]  = '{4'd1, 0, 4'd2, 0, 4'd3, 0, 0, 4'd4, 0, 1, 0, 1, 4'b0110, 4'b0110};
    vecs[9]  = '{4'd3, 1, 4'd0, 0, 4'd3, 1, 1, 4'd0, 0, 1, 1, 0, 4'b0001, 4'b0001};
    vecs[10] = '{4'd3, 1, 4'd0, 0, 4'd3, 1, 1, 4'd0, 0, 1, 1, 1, 4'b0110, 4'b0110};
    vecs[11] = '{4'd1, 0, 4'd5, 1, 4'd5, 1, 1, 4'd9, 0, 0, 1, 1, 4'b1010, 4'b1010};
    vecs[12] = '{4'd0, 0, 4'd9, 1, 4'd1, 1, 0, 4'd9, 1, 0, 0, 1, 4'b1010, 4'b0000};
    lu = vecs[2];

    // Reset state
    rst_n = 1'b0;
    idle();
    model_reset();
    #1;
    chk("reset.if_freeze",    {31'd0, bus.if_freeze}, 0);
    chk("reset.if_flush",     {31'd0, bus.if_flush}, 0);
    chk("reset.id_flush",     {31'd0, bus.id_flush}, 0);
    chk("reset.pipe_freeze",  {31'd0, bus.pipe_freeze}, 0);
    chk("reset.mem_timeout",  {31'd0, bus.mem_timeout}, 0);
    chk("reset.stall_cycles", {28'd0, bus.stall_cycles}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 13; i++) begin
      apply(vecs[i]);
      #2;
`ifdef HAZ_FORWARDING_EN
      e = vecs[i].exp_fw;
`else
      e = vecs[i].exp_nf;
`endif
      chk($sformatf("vec%0d.if_freeze", i),   {31'd0, bus.if_freeze},   {31'd0, e[3]});
      chk($sformatf("vec%0d.if_flush", i),    {31'd0, bus.if_flush},    {31'd0, e[2]});
      chk($sformatf("vec%0d.id_flush", i),    {31'd0, bus.id_flush},    {31'd0, e[1]});
      chk($sformatf("vec%0d.pipe_freeze", i), {31'd0, bus.pipe_freeze}, {31'd0, e[0]});
      $display("vec %0d: outs=%b%b%b%b want=%b", i, bus.if_freeze, bus.if_flush,
               bus.id_flush, bus.pipe_freeze, e);
      run_cycle($sformatf("vec%0d", i));
    end

    // Load-use for one cycle, then the bubble moves on and the load sits in MEM
    do_reset();
    apply(lu);
    run_cycle("lu.a");
    v = lu; v.ewb = 0; v.erd = 0; v.ed = 4'd0; v.md = 4'd5; v.mwb = 1;
    apply(v);
    #2;
`ifdef HAZ_FORWARDING_EN
    chk("lu.b.if_freeze", {31'd0, bus.if_freeze}, 0);
`else
    chk("lu.b.if_freeze", {31'd0, bus.if_freeze}, 1);
`endif
    run_cycle("lu.b");
    v.mwb = 0;
    apply(v);
    run_cycle("lu.c");
    chk("lu.stall_cycles", {28'd0, bus.stall_cycles},
`ifdef HAZ_FORWARDING_EN
        1);
`else
        2);
`endif
    $display("seq load_use: stall_cycles=%0d", bus.stall_cycles);

    // Memory wait with a pending branch: branch ignored while frozen
    do_reset();
    v = vecs[8]; v.mreq = 1; v.mrdy = 0;
    apply(v);
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("wait.pipe_freeze", {31'd0, bus.pipe_freeze}, 1);
      chk("wait.if_flush",    {31'd0, bus.if_flush}, 0);
      run_cycle("wait");
    end
    v.mrdy = 1;
    apply(v);
    #2;
    chk("release.pipe_freeze", {31'd0, bus.pipe_freeze}, 0);
    chk("release.if_flush",    {31'd0, bus.if_flush}, 1);
    run_cycle("release");
    $display("seq mem_wait: released, if_flush=%0d", bus.if_flush);

    // Timeout: WAIT_LIMIT+2 frozen cycles, sticky until reset
    do_reset();
    v.br = 0; v.mrdy = 0;
    apply(v);
    for (int i = 0; i < WAIT_LIMIT + 1; i++) run_cycle("tmo");
    chk("tmo.before", {31'd0, bus.mem_timeout}, 0);
    run_cycle("tmo");
    chk("tmo.after", {31'd0, bus.mem_timeout}, 1);
    v.mrdy = 1;
    apply(v);
    run_cycle("tmo.rdy");
    idle();
    repeat (3) run_cycle("tmo.idle");
    chk("tmo.sticky", {31'd0, bus.mem_timeout}, 1);
    $display("seq timeout: mem_timeout=%0d", bus.mem_timeout);
    do_reset();
    #2 chk("tmo.cleared", {31'd0, bus.mem_timeout}, 0);
    #4;  // back to posedge+1 after the next edge
    @(posedge clk); #1;

    // Async reset mid-wait with 9 stall cycles counted
    do_reset();
    apply(lu);
    repeat (9) run_cycle("pre");
    chk("pre.stall_cycles", {28'd0, bus.stall_cycles}, 9);
    v = lu; v.mreq = 1; v.mrdy = 0;
    apply(v);
    repeat (2) run_cycle("pre.wait");
    #3 rst_n = 1'b0;
    #1;
    chk("arst.pipe_freeze",  {31'd0, bus.pipe_freeze}, 0);
    chk("arst.if_freeze",    {31'd0, bus.if_freeze}, 0);
    chk("arst.if_flush",     {31'd0, bus.if_flush}, 0);
    chk("arst.id_flush",     {31'd0, bus.id_flush}, 0);
    chk("arst.mem_timeout",  {31'd0, bus.mem_timeout}, 0);
    chk("arst.stall_cycles", {28'd0, bus.stall_cycles}, 0);
    $display("seq async_reset: stall_cycles=%0d", bus.stall_cycles);
    model_reset();
    @(posedge clk); #1;
    idle();
    rst_n = 1'b1;
    run_cycle("post.arst");

    // Saturation of stall_cycles
    do_reset();
    apply(lu);
    repeat (CNT_MAX + 5) run_cycle("sat");
    chk("sat.stall_cycles", {28'd0, bus.stall_cycles}, CNT_MAX);
    $display("seq saturate: stall_cycles=%0d", bus.stall_cycles);

    // Randomized run; a pending access stays requested until ready
    do_reset();
    prev_frz = 0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 250 == 249) begin
        do_reset();
        prev_frz = 0;
      end
      v.s1 = 4'($urandom_range(0, 7)); v.v1 = 1'($urandom_range(0, 1));
      v.s2 = 4'($urandom_range(0, 7)); v.v2 = 1'($urandom_range(0, 1));
      v.ed = 4'($urandom_range(0, 7)); v.ewb = 1'($urandom_range(0, 1));
      v.erd = 1'($urandom_range(0, 1));
      v.md = 4'($urandom_range(0, 7)); v.mwb = 1'($urandom_range(0, 1));
      v.br = ($urandom % 6 == 0);
      v.mreq = prev_frz ? 1'b1 : ($urandom % 4 == 0);
      v.mrdy = ($urandom % 3 != 0);
      apply(v);
      prev_frz = v.mreq && !v.mrdy;
      run_cycle($sformatf("rnd%0d", i));
    end
    $display("random: 1500 cycles done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
